// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
//   start, a, b, bin : request and operands, driven by the master
//   busy, done       : progress flags, driven by the subtractor
//   diff, bout, ovf  : result, borrow-out and signed overflow, driven by the subtractor
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per cycle, LSB first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if slave (start/a/b/bin in; busy/done/diff/bout/ovf out)
// A start in IDLE or DONE latches the operands; WIDTH RUN cycles later the result,
// borrow-out and overflow update together and done pulses for one cycle.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic d_bit;
  logic borrow_nxt;
  logic last;

  // Full subtractor on the current LSBs of the operand shift registers.
  assign d_bit      = a_q[0] ^ b_q[0] ^ borrow_q;
  assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
  assign last       = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
          // On the last bit a_q[0]/b_q[0] hold the original operand MSBs.
          ovf_d   = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule
